// File: rtl/rnd_frame_bank_pkg.sv
// rtl/rnd_frame_bank_pkg.sv - shared state encoding and LFSR definition for the random frame bank
package rnd_frame_bank_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN     = 2'd1,
    WAIT_VB = 2'd2,
    COMMIT  = 2'd3
  } rfb_state_t;

  localparam int LFSR_LEN = 16;
  // x^16+x^15+x^13+x^4+1 -> taps on bits 15, 14, 12, 3
  localparam logic [LFSR_LEN-1:0] LFSR_TAPS    = 16'hD008;
  localparam logic [LFSR_LEN-1:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [LFSR_LEN-1:0] lfsr_step(input logic [LFSR_LEN-1:0] s);
    return {s[LFSR_LEN-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rnd_frame_bank_lfsr_core.sv
// rtl/rnd_frame_bank_lfsr_core.sv - 16-bit Fibonacci LFSR with step enable and lock-up reload
module rnd_frame_bank_lfsr_core
  import rnd_frame_bank_pkg::*;
#(
  parameter logic [LFSR_LEN-1:0] SEED = DEFAULT_SEED
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                step_en,
  output logic [LFSR_LEN-1:0] lfsr_q,
  output logic [LFSR_LEN-1:0] lfsr_next
);

  assign lfsr_next = lfsr_step(lfsr_q);

  // An all-zero register would never leave zero, so it is reseeded regardless of step_en.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else if (lfsr_q == '0) begin
      lfsr_q <= SEED;
    end else if (step_en) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/rnd_frame_bank.sv
// rtl/rnd_frame_bank.sv - generates a bank of random words on tempo and commits them at vblank
module rnd_frame_bank
  import rnd_frame_bank_pkg::*;
#(
  parameter int                  N_WORDS = 10,
  parameter int                  WIDTH   = 13,
  parameter logic [LFSR_LEN-1:0] SEED    = DEFAULT_SEED
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       update_pulse,
  input  logic                       vblank_pulse,
  output logic [N_WORDS*WIDTH-1:0]   rnd_bus,
  output logic                       busy,
  output logic                       committed
);

  localparam int WI_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int SC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WI_W-1:0] WORD_LAST = WI_W'(N_WORDS - 1);
  localparam logic [SC_W-1:0] STEP_LAST = SC_W'(WIDTH - 1);

  rfb_state_t                 state;
  rfb_state_t                 state_nxt;
  logic [WI_W-1:0]            word_idx;
  logic [SC_W-1:0]            step_cnt;
  logic                       pending;
  logic [N_WORDS*WIDTH-1:0]   shadow;
  logic [LFSR_LEN-1:0]        lfsr_q;
  logic [LFSR_LEN-1:0]        lfsr_next;
  logic                       unused_lfsr;

  rnd_frame_bank_lfsr_core #(
    .SEED(SEED)
  ) u_lfsr_core (
    .clk_in   (clk_in),
    .reset    (reset),
    .step_en  (state == GEN),
    .lfsr_q   (lfsr_q),
    .lfsr_next(lfsr_next)
  );

  assign unused_lfsr = ^{lfsr_q, lfsr_next};
  assign busy        = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (update_pulse || pending) state_nxt = GEN;
      GEN:     if (step_cnt == STEP_LAST && word_idx == WORD_LAST) state_nxt = WAIT_VB;
      WAIT_VB: if (vblank_pulse) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      word_idx  <= '0;
      step_cnt  <= '0;
      pending   <= 1'b0;
      shadow    <= '0;
      rnd_bus   <= '0;
      committed <= 1'b0;
    end else begin
      committed <= 1'b0;
      case (state)
        IDLE: begin
          if (update_pulse || pending) begin
            pending  <= 1'b0;
            word_idx <= '0;
            step_cnt <= '0;
          end
        end
        GEN: begin
          if (update_pulse) pending <= 1'b1;
          // Each word takes the post-step value after WIDTH fresh shifts.
          if (step_cnt == STEP_LAST) begin
            for (int k = 0; k < N_WORDS; k++) begin
              if (word_idx == WI_W'(k)) shadow[k*WIDTH +: WIDTH] <= lfsr_next[WIDTH-1:0];
            end
            step_cnt <= '0;
            word_idx <= word_idx + WI_W'(1);
          end else begin
            step_cnt <= step_cnt + SC_W'(1);
          end
        end
        WAIT_VB: begin
          if (update_pulse) pending <= 1'b1;
        end
        COMMIT: begin
          if (update_pulse) pending <= 1'b1;
          rnd_bus   <= shadow;
          committed <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rnd_frame_bank.sv
// tb/tb_rnd_frame_bank.sv - scoreboard bench for rnd_frame_bank
module tb_rnd_frame_bank;

  localparam int NW = 10;
  localparam int WD = 13;
  localparam int BW = NW * WD;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          update_pulse = 1'b0;
  logic          vblank_pulse = 1'b0;
  logic [BW-1:0] rnd_bus;
  logic          busy;
  logic          committed;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [BW-1:0] bus;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  logic [BW-1:0] w1, w2, w3, w4;
  logic [15:0]   s1, s2, s3, s4;

  rnd_frame_bank dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .update_pulse(update_pulse),
    .vblank_pulse(vblank_pulse),
    .rnd_bus     (rnd_bus),
    .busy        (busy),
    .committed   (committed)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference generator: x^16+x^15+x^13+x^4+1, shift left, feedback into bit 0.
  task automatic model_set(input logic [15:0] s_in, output logic [BW-1:0] bus, output logic [15:0] s_out);
    logic [15:0] s;
    s   = s_in;
    bus = '0;
    for (int k = 0; k < NW; k++) begin
      for (int j = 0; j < WD; j++) s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
      bus[k*WD +: WD] = s[WD-1:0];
    end
    s_out = s;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse_update();
    update_pulse = 1'b1;
    tick();
    update_pulse = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank_pulse = 1'b1;
    tick();
    vblank_pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (committed === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: committed=1 with nothing expected (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_cycle", BW'(cyc), BW'(e.cyc));
        check("commit_bus", rnd_bus, e.bus);
      end
    end
  end

  initial begin
    int t;
    model_set(16'hACE1, w1, s1);
    model_set(s1, w2, s2);

    // reset and idle
    do_reset();
    repeat (50) tick();
    check("reset_bus", rnd_bus, '0);
    check("reset_busy", BW'(busy), BW'(0));
    check("reset_lfsr", BW'(dut.u_lfsr_core.lfsr_q), BW'(16'hACE1));

    // single update
    t = cyc;
    sb.push_back('{w1, t + 202});
    pulse_update();
    check("single_busy_rise", BW'(busy), BW'(1));
    wait_until(t + 200);
    pulse_vblank();
    check("single_bus_hold", rnd_bus, '0);
    wait_until(t + 205);

    // vblank during GEN is ignored
    do_reset();
    t = cyc;
    sb.push_back('{w1, t + 402});
    pulse_update();
    wait_until(t + 50);
    pulse_vblank();
    wait_until(t + 400);
    pulse_vblank();
    wait_until(t + 405);

    // coalesced pulses, then pending restart
    do_reset();
    t = cyc;
    sb.push_back('{w1, t + 302});
    sb.push_back('{w2, t + 452});
    pulse_update();
    wait_until(t + 10);
    pulse_update();
    wait_until(t + 20);
    pulse_update();
    wait_until(t + 300);
    pulse_vblank();
    wait_until(t + 302);
    check("coal_idle", BW'(busy), BW'(0));
    tick();
    check("coal_restart", BW'(busy), BW'(1));
    wait_until(t + 450);
    pulse_vblank();
    wait_until(t + 455);

    // update and vblank together in WAIT_VB
    model_set(s2, w3, s3);
    model_set(s3, w4, s4);
    t = cyc;
    sb.push_back('{w3, t + 152});
    sb.push_back('{w4, t + 302});
    pulse_update();
    wait_until(t + 150);
    update_pulse = 1'b1;
    pulse_vblank();
    update_pulse = 1'b0;
    check("simul_pending", BW'(dut.pending), BW'(1));
    tick();
    check("simul_idle", BW'(busy), BW'(0));
    tick();
    check("simul_regen", BW'(busy), BW'(1));
    wait_until(t + 300);
    pulse_vblank();
    wait_until(t + 305);

    // reset mid-GEN, then a fresh run matches the first word set
    t = cyc;
    pulse_update();
    wait_until(t + 60);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_bus", rnd_bus, '0);
    check("midreset_busy", BW'(busy), BW'(0));
    t = cyc;
    sb.push_back('{w1, t + 202});
    pulse_update();
    wait_until(t + 200);
    pulse_vblank();
    wait_until(t + 210);

    check("sb_drained", BW'(sb.size()), BW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rnd_frame_bank.md
Name: rnd_frame_bank

Overview:
- Upstream feeder for the square-pattern colour stage.
- Generates N_WORDS pseudo-random words of WIDTH bits from one 16-bit LFSR when the tempo pulse arrives, and stages them in shadow registers.
- Commits all words to the output bus together at vertical blanking, so rectangle bounds and colours never change mid-frame (no tearing).

Parameters:
- N_WORDS, 10, number of random words produced per update.
- WIDTH, 13, bits per word.
- SEED, 16'hACE1, LFSR reset and lock-up reload value. Must be non-zero.

Ports:
- clk_in  input  1  pixel clock; the single clock domain.
- reset  input  1  synchronous, active-high reset.
- update_pulse  input  1  one-cycle request for a new word set (tempo half-second pulse).
- vblank_pulse  input  1  one-cycle pulse on the first cycle of vertical blanking.
- rnd_bus  output  N_WORDS*WIDTH  committed words; word k occupies bits [k*WIDTH +: WIDTH].
- busy  output  1  high whenever state is not IDLE.
- committed  output  1  one-cycle pulse in the cycle rnd_bus updates.

Behaviour:
- LFSR
  - 16-bit Fibonacci, polynomial x^16+x^15+x^13+x^4+1.
  - Shift left; feedback = s[15]^s[14]^s[12]^s[3] enters bit 0.
  - Steps only while state is GEN.
  - If the state register is ever 0, the next clock loads SEED instead of stepping (lock-up recovery).
- Reset (synchronous)
  - state=IDLE, lfsr=SEED, rnd_bus=0, shadow=0, word_idx=0, step_cnt=0, pending=0, busy=0, committed=0.
- IDLE
  - If update_pulse or pending is set: go to GEN next cycle, clear pending, word_idx=0, step_cnt=0.
- GEN
  - LFSR steps once per cycle.
  - When step_cnt==WIDTH-1: shadow[word_idx] <= low WIDTH bits of the post-step LFSR value, step_cnt=0, word_idx++. Otherwise step_cnt++.
  - After word N_WORDS-1 is written, go to WAIT_VB.
  - GEN lasts exactly N_WORDS*WIDTH cycles (130 at defaults).
- WAIT_VB
  - Holds until vblank_pulse is sampled high while in this state, then goes to COMMIT.
- COMMIT (one cycle)
  - rnd_bus <= shadow, registered at the end of this cycle.
  - committed is high in the cycle the new rnd_bus value appears.
  - Return to IDLE.
- Latency
  - update_pulse at cycle t → busy=1 at t+1 → WAIT_VB entered at t+1+N_WORDS*WIDTH.
  - rnd_bus changes 2 cycles after the vblank_pulse sampled in WAIT_VB.
- Boundary rules
  - update_pulse while busy sets pending. Multiple pulses collapse into one pending request; shadow is never modified outside GEN.
  - update_pulse in the same cycle as the COMMIT→IDLE transition sets pending; a new GEN starts from IDLE on the following cycle.
  - vblank_pulse in IDLE, GEN or COMMIT is ignored and not remembered. A frame that ends mid-GEN waits for the next frame.
  - update_pulse and vblank_pulse together in WAIT_VB: commit proceeds, pending is set.
  - Reset mid-GEN or mid-WAIT_VB discards shadow progress; rnd_bus returns to 0.
- Width rule: N_WORDS*WIDTH output width is computed from the parameters; word_idx is $clog2(N_WORDS) bits wide, step_cnt is $clog2(WIDTH) bits wide.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, GEN, WAIT_VB, COMMIT);
  - LFSR_LEN=16, the LFSR tap mask and the default SEED constant, so the colour stage and bench use the same generator definition.
- One sub-module, lfsr_core:
  - 16-bit register with step enable and lock-up reload;
  - outputs the current state and the next value.
- FSM, counters and the shadow/output banks stay in rnd_frame_bank.

Test Plan:
- Reset sequence: reset=1 for 2 cycles, then idle 50 cycles → rnd_bus==0, busy==0, committed never pulses, LFSR internal value==16'hACE1.
- Single update: update_pulse at t, vblank_pulse at t+200 → busy rises at t+1; rnd_bus stays 0 until t+202; committed high exactly at t+202; each word matches the bench model (SEED, 13 steps per word, low 13 bits).
- Early vblank: vblank_pulse at t+50 (during GEN), next at t+400 → no commit at t+52; commit at t+402 with the same words as the single-update case.
- Pulse coalescing: update_pulse at t, t+10 and t+20, vblank at t+300 → one commit at t+302. GEN restarts at t+303; a second commit on the next vblank carries words 10-19 of the model sequence.
- Simultaneous events: update_pulse and vblank_pulse together while in WAIT_VB → commit occurs, pending=1, and GEN begins one cycle after returning to IDLE.
- Reset mid-operation: reset asserted at GEN cycle 60 after a prior commit → rnd_bus==0 and state==IDLE next cycle. A fresh update_pulse then reproduces the single-update word set exactly.
